// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache: 16 lines x 32 bytes, one-word CPU port.
// Hits complete in the request cycle; misses stall through WRITEBACK/ALLOCATE/REFILL.
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_e;

  state_e         state_q, state_d;
  logic [15:0]    valid_q, dirty_q;
  logic [22:0]    tag_q  [16];
  logic [255:0]   data_q [16];

  logic [3:0]     idx;
  logic [2:0]     word;
  logic [22:0]    tag;
  logic [7:0]     word_base;
  logic           req, hit, victim_dirty, alloc_done;
  logic           addr_unused;

  assign idx          = cpu_addr_i[8:5];
  assign word         = cpu_addr_i[4:2];
  assign tag          = cpu_addr_i[31:9];
  assign word_base    = {word, 5'b0};
  assign addr_unused  = ^cpu_addr_i[1:0];
  assign req          = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit          = (state_q == IDLE) && req && valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];
  assign alloc_done   = (state_q == ALLOCATE) && mem_ack_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (req && !hit) state_d = victim_dirty ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ack_i) state_d = REFILL;
      REFILL:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (hit && cpu_MemWrite_i) dirty_q[idx] <= 1'b1;
      if (alloc_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tag/data arrays carry no reset: valid bits alone decide whether contents count.
  always_ff @(posedge clk_i) begin
    if (hit && cpu_MemWrite_i) data_q[idx][word_base +: 32] <= cpu_data_i;
    if (alloc_done) begin
      data_q[idx] <= mem_data_i;
      tag_q[idx]  <= tag;
    end
  end

  // Stall is gated by reset so a request held across reset does not show as a miss.
  assign cpu_stall_o  = rst_i & ((state_q != IDLE) | (req & ~hit));
  assign cpu_data_o   = (hit && !cpu_MemWrite_i) ? data_q[idx][word_base +: 32] : 32'h0;
  assign mem_enable_o = (state_q == WRITEBACK) || (state_q == ALLOCATE);
  assign mem_write_o  = (state_q == WRITEBACK);
  assign mem_data_o   = (state_q == WRITEBACK) ? data_q[idx] : 256'h0;

  always_comb begin
    mem_addr_o = 32'h0;
    if (state_q == WRITEBACK) mem_addr_o = {tag_q[idx], idx, 5'b0};
    else if (state_q == ALLOCATE) mem_addr_o = {tag, idx, 5'b0};
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: inputs driven on the falling edge, outputs sampled 1ns later.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int checks = 0;
  int errors = 0;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] make_line(input logic [31:0] base, input logic [31:0] w2);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
    l[95:64] = w2;
    return l;
  endfunction

  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0; mem_data_i = '0; mem_ack_i = 1'b0;
    repeat (2) next_cycle();
    #1;
    checks++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'h0 || mem_enable_o !== 1'b0 ||
        mem_write_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_data_o !== 256'h0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b data=%h en=%b wr=%b addr=%h mdata_w0=%h, required all 0",
               cpu_stall_o, cpu_data_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o[31:0]);
    end
    next_cycle();
    rst_i = 1'b1;
    next_cycle(); #1;
    checks++;
    if (cpu_stall_o !== 1'b0) begin
      errors++; $display("FAIL idle_no_req_stall: got %b, required 0", cpu_stall_o);
    end
  endtask

  task automatic test_clean_miss();
    next_cycle();
    cpu_addr_i = 32'h40; cpu_MemRead_i = 1'b1; #1;
    checks++;
    if (cpu_stall_o !== 1'b1 || mem_enable_o !== 1'b0) begin
      errors++; $display("FAIL miss_stall_same_cycle: stall=%b en=%b, required 1/0", cpu_stall_o, mem_enable_o);
    end
    next_cycle(); #1;
    checks++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h40 || cpu_stall_o !== 1'b1) begin
      errors++; $display("FAIL allocate_40: en=%b wr=%b addr=%h stall=%b, required 1/0/00000040/1",
                         mem_enable_o, mem_write_o, mem_addr_o, cpu_stall_o);
    end
    mem_data_i = make_line(32'h1000_0000, 32'hDEADBEEF); mem_ack_i = 1'b1;
    next_cycle(); mem_ack_i = 1'b0; #1;
    checks++;
    if (cpu_stall_o !== 1'b1 || mem_enable_o !== 1'b0) begin
      errors++; $display("FAIL refill_cycle: stall=%b en=%b, required 1/0", cpu_stall_o, mem_enable_o);
    end
    next_cycle(); #1;
    checks++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'h1000_0000) begin
      errors++; $display("FAIL held_load_40: stall=%b data=%h, required 0/10000000", cpu_stall_o, cpu_data_o);
    end
    next_cycle();
    cpu_addr_i = 32'h48; #1;
    checks++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_48: stall=%b data=%h, required 0/deadbeef", cpu_stall_o, cpu_data_o);
    end
  endtask

  task automatic test_write_hit();
    next_cycle();
    cpu_addr_i = 32'h44; cpu_data_i = 32'h1234_5678; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b1; #1;
    checks++;
    if (cpu_stall_o !== 1'b0) begin
      errors++; $display("FAIL store_hit_stall: got %b, required 0", cpu_stall_o);
    end
    next_cycle();
    cpu_MemWrite_i = 1'b0; cpu_MemRead_i = 1'b1; #1;
    checks++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'h1234_5678) begin
      errors++; $display("FAIL load_after_store: stall=%b data=%h, required 0/12345678", cpu_stall_o, cpu_data_o);
    end
    next_cycle();
    cpu_MemRead_i = 1'b0; #1;
    checks++;
    if (cpu_data_o !== 32'h0 || cpu_stall_o !== 1'b0) begin
      errors++; $display("FAIL no_req_outputs: data=%h stall=%b, required 0/0", cpu_data_o, cpu_stall_o);
    end
  endtask

  task automatic test_dirty_miss();
    next_cycle();
    cpu_addr_i = 32'h240; cpu_MemRead_i = 1'b1; #1;
    checks++;
    if (cpu_stall_o !== 1'b1) begin
      errors++; $display("FAIL dirty_miss_stall: got %b, required 1", cpu_stall_o);
    end
    next_cycle(); #1;
    checks++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h40 ||
        mem_data_o[63:32] !== 32'h1234_5678 || mem_data_o[95:64] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL writeback_40: en=%b wr=%b addr=%h w1=%h w2=%h, required 1/1/00000040/12345678/deadbeef",
                         mem_enable_o, mem_write_o, mem_addr_o, mem_data_o[63:32], mem_data_o[95:64]);
    end
    mem_ack_i = 1'b1;
    next_cycle(); mem_ack_i = 1'b0; #1;
    checks++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h240 || cpu_stall_o !== 1'b1) begin
      errors++; $display("FAIL allocate_240: en=%b wr=%b addr=%h stall=%b, required 1/0/00000240/1",
                         mem_enable_o, mem_write_o, mem_addr_o, cpu_stall_o);
    end
    mem_data_i = make_line(32'hB000_0000, 32'hB000_0002); mem_ack_i = 1'b1;
    next_cycle(); mem_ack_i = 1'b0;
    next_cycle(); #1;
    checks++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'hB000_0000) begin
      errors++; $display("FAIL load_240: stall=%b data=%h, required 0/b0000000", cpu_stall_o, cpu_data_o);
    end
  endtask

  task automatic test_both_high();
    next_cycle();
    cpu_addr_i = 32'h244; cpu_data_i = 32'hA5A5_A5A5; cpu_MemRead_i = 1'b1; cpu_MemWrite_i = 1'b1; #1;
    checks++;
    if (cpu_stall_o !== 1'b0) begin
      errors++; $display("FAIL both_high_stall: got %b, required 0", cpu_stall_o);
    end
    next_cycle();
    cpu_MemWrite_i = 1'b0; #1;
    checks++;
    if (cpu_data_o !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL both_high_stored: got %h, required a5a5a5a5", cpu_data_o);
    end
    next_cycle();
    cpu_addr_i = 32'h40;
    next_cycle(); #1;
    checks++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h240 ||
        mem_data_o[63:32] !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL both_high_dirty_wb: en=%b wr=%b addr=%h w1=%h, required 1/1/00000240/a5a5a5a5",
                         mem_enable_o, mem_write_o, mem_addr_o, mem_data_o[63:32]);
    end
    mem_ack_i = 1'b1;
    next_cycle();
    mem_data_i = make_line(32'hC000_0000, 32'hC000_0002);
    next_cycle(); mem_ack_i = 1'b0;
    next_cycle(); #1;
    checks++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'hC000_0000) begin
      errors++; $display("FAIL reload_40: stall=%b data=%h, required 0/c0000000", cpu_stall_o, cpu_data_o);
    end
    next_cycle();
    cpu_MemRead_i = 1'b0;
  endtask

  task automatic test_reset_mid_miss();
    next_cycle();
    cpu_addr_i = 32'h80; cpu_MemRead_i = 1'b1;
    next_cycle(); #1;
    checks++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h80) begin
      errors++; $display("FAIL pre_reset_allocate: en=%b addr=%h, required 1/00000080", mem_enable_o, mem_addr_o);
    end
    rst_i = 1'b0; #1;
    checks++;
    if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_mid_allocate: en=%b stall=%b addr=%h, required 0/0/0",
                         mem_enable_o, cpu_stall_o, mem_addr_o);
    end
    next_cycle();
    cpu_MemRead_i = 1'b0; rst_i = 1'b1;
    next_cycle();
    mem_data_i = make_line(32'hE000_0000, 32'hE000_0002); mem_ack_i = 1'b1;
    next_cycle(); mem_ack_i = 1'b0; #1;
    checks++;
    if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      errors++; $display("FAIL late_ack_ignored: en=%b stall=%b, required 0/0", mem_enable_o, cpu_stall_o);
    end
    next_cycle();
    cpu_MemRead_i = 1'b1; #1;
    checks++;
    if (cpu_stall_o !== 1'b1) begin
      errors++; $display("FAIL reload_after_reset_miss: stall=%b, required 1", cpu_stall_o);
    end
    next_cycle(); #1;
    checks++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0) begin
      errors++; $display("FAIL reset_cleared_dirty: en=%b wr=%b, required 1/0", mem_enable_o, mem_write_o);
    end
    mem_ack_i = 1'b1;
    next_cycle(); mem_ack_i = 1'b0;
    next_cycle(); #1;
    checks++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'hE000_0000) begin
      errors++; $display("FAIL post_reset_load_80: stall=%b data=%h, required 0/e0000000", cpu_stall_o, cpu_data_o);
    end
    next_cycle();
    cpu_MemRead_i = 1'b0;
  endtask

  task automatic test_ack_latency();
    int stall_cnt = 0;
    int en_cnt = 0;
    bit done = 1'b0;
    next_cycle();
    cpu_addr_i = 32'hC0; cpu_MemRead_i = 1'b1;
    mem_data_i = make_line(32'hF000_0000, 32'hF000_0002);
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      if (cpu_stall_o) stall_cnt++;
      else done = 1'b1;
      if (mem_enable_o) en_cnt++;
      mem_ack_i = mem_enable_o && (en_cnt == 10);
      if (!done) next_cycle();
    end
    checks++;
    if (!done || stall_cnt != 12) begin
      errors++; $display("FAIL ack_delay_10_stall: done=%b stall_cycles=%0d, required 1/12", done, stall_cnt);
    end
    checks++;
    if (cpu_data_o !== 32'hF000_0000) begin
      errors++; $display("FAIL ack_delay_load: got %h, required f0000000", cpu_data_o);
    end
    next_cycle();
    cpu_MemRead_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_miss();
    test_both_high();
    test_reset_mid_miss();
    test_ack_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
